// File: rtl/ram_storage.sv
// ram_storage: single-port DEPTH x DATA_W RAM with a 1-cycle registered read and a zero-fill sweep after reset.
// Optional macro RAM_STORAGE_WRITE_THROUGH_EN: a same-address read during a write returns the new data.
module ram_storage #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 145,
   parameter int DEPTH  = 4096
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   output logic [DATA_W-1:0] q,
   output logic              ready
);

   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_sweep_ptr;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_q;
   logic              w_addr_ok;
   logic              w_sweep_wr;
   logic              w_user_wr;

   // Addresses beyond DEPTH (only possible when DEPTH < 2**ADDR_W) neither write nor read.
   assign w_addr_ok = ({1'b0, address} < LP_DEPTH);
   assign w_user_wr = (r_state == ST_RUN) && wren && w_addr_ok;

   always_comb begin
      w_state_nxt = r_state;
      w_sweep_wr  = 1'b0;
      case (r_state)
         ST_SWEEP: begin
            w_sweep_wr = 1'b1;
            if (r_sweep_ptr == LP_LAST) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_SWEEP;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_state     <= ST_SWEEP;
         r_sweep_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_sweep_wr) begin
            r_sweep_ptr <= r_sweep_ptr + ADDR_W'(1);
         end
      end
   end

   // Storage has no reset of its own: the sweep is the only thing that clears it.
   always_ff @(posedge clock) begin
      if (rst_n) begin
         if (w_sweep_wr) begin
            r_mem[r_sweep_ptr] <= '0;
         end else if (w_user_wr) begin
            r_mem[address] <= data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (r_state != ST_RUN) begin
         r_q <= '0;
      end else if (!w_addr_ok) begin
         r_q <= '0;
      end
`ifdef RAM_STORAGE_WRITE_THROUGH_EN
      else if (wren) begin
         r_q <= data;
      end
`endif
      else begin
         r_q <= r_mem[address];
      end
   end

   assign q     = r_q;
   assign ready = (r_state == ST_RUN);

endmodule

// File: tb/tb_ram_storage.sv
// Randomized self-checking bench for ram_storage against a whole-array reference model.
// Honours RAM_STORAGE_WRITE_THROUGH_EN to pick the expected read-during-write result.
module tb_ram_storage;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 145;
   localparam int DEPTH  = 4096;

   logic              clock = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] data = '0;
   logic              wren = 1'b0;
   logic [DATA_W-1:0] q;
   logic              ready;

   ram_storage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock   (clock),
      .rst_n   (rst_n),
      .address (address),
      .data    (data),
      .wren    (wren),
      .q       (q),
      .ready   (ready)
   );

   always #5 clock = ~clock;

   // Reference model: reset wipes the whole array at once; the RAM becomes usable after DEPTH released edges.
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [DATA_W-1:0] m_q;
   int                m_cnt;
   int                n_vec = 0;
   int                n_err = 0;

`ifdef RAM_STORAGE_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", tag, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rnd_word();
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return w[DATA_W-1:0];
   endfunction

   function automatic bit m_ready();
      return m_cnt >= DEPTH;
   endfunction

   // One clock: apply inputs, advance the model, then compare just after the edge.
   task automatic cyc(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] old;
      rst_n = r; wren = w; address = a; data = d;
      @(posedge clock);
      if (!r) begin
         m_cnt = 0;
         m_q   = '0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else if (!m_ready()) begin
         m_cnt++;
         m_q = '0;
      end else begin
         old = m_mem[a];
         if (w) m_mem[a] = d;
         m_q = (WT && w) ? d : old;
      end
      #1;
      check("q", q, m_q);
      check("ready", {{(DATA_W-1){1'b0}}, ready}, {{(DATA_W-1){1'b0}}, m_ready()});
   endtask

   // Sweep phase with garbage user traffic that must be ignored; address 10 is hammered.
   task automatic sweep_with_noise(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         if (i % 2 == 0) cyc(1'b1, 1'b1, ADDR_W'(10), rnd_word() | {{(DATA_W-1){1'b0}}, 1'b1});
         else            cyc(1'b1, 1'($urandom), ADDR_W'($urandom), rnd_word());
      end
   endtask

   initial begin
      logic [DATA_W-1:0] val5;
      logic [DATA_W-1:0] va, vb;
      m_cnt = 0;
      m_q   = '0;

      // Reset for two cycles, then exactly DEPTH sweep cycles before ready.
      cyc(1'b0, 1'b1, ADDR_W'(10), rnd_word());
      cyc(1'b0, 1'b1, ADDR_W'(3), rnd_word());
      check("ready_low_in_reset", {{(DATA_W-1){1'b0}}, ready}, '0);
      sweep_with_noise(DEPTH - 1);
      check("ready_before_last", {{(DATA_W-1){1'b0}}, ready}, '0);
      sweep_with_noise(1);
      check("ready_after_sweep", {{(DATA_W-1){1'b0}}, ready}, {{(DATA_W-1){1'b0}}, 1'b1});

      cyc(1'b1, 1'b0, ADDR_W'(0), '0);
      check("rd_addr0", q, '0);
      cyc(1'b1, 1'b0, ADDR_W'(DEPTH-1), '0);
      check("rd_addr4095", q, '0);
      cyc(1'b1, 1'b0, ADDR_W'(10), '0);
      check("rd_addr10", q, '0);

      // Single write/read with the MSB and valid bit set.
      val5 = '0;
      val5[DATA_W-1] = 1'b1;
      val5[0] = 1'b1;
      cyc(1'b1, 1'b1, ADDR_W'(5), val5);
      cyc(1'b1, 1'b0, ADDR_W'(5), '0);
      check("rd_addr5", q, val5);

      // Same-address read during write.
      va = rnd_word();
      vb = ~va;
      cyc(1'b1, 1'b1, ADDR_W'(7), va);
      cyc(1'b1, 1'b1, ADDR_W'(7), vb);
      check("rdw_addr7", q, WT ? vb : va);
      cyc(1'b1, 1'b0, ADDR_W'(7), '0);
      check("rd_addr7_after", q, vb);

      // Back-to-back writes then reads of 0..15.
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i));
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, ADDR_W'(i), '0);
         check("b2b_read", q, DATA_W'(i));
      end

      // Random traffic on a small address window to force collisions.
      for (int i = 0; i < 2000; i++) begin
         cyc(1'b1, 1'($urandom), ADDR_W'($urandom_range(0, 31)), rnd_word());
      end

      // Write address 3, reset, then pulse reset again 100 cycles into the sweep.
      cyc(1'b1, 1'b1, ADDR_W'(3), rnd_word() | {{(DATA_W-1){1'b0}}, 1'b1});
      cyc(1'b0, 1'b0, '0, '0);
      sweep_with_noise(100);
      cyc(1'b0, 1'b1, ADDR_W'(3), rnd_word());
      sweep_with_noise(DEPTH - 1);
      check("ready_held_after_2nd_reset", {{(DATA_W-1){1'b0}}, ready}, '0);
      sweep_with_noise(1);
      check("ready_after_2nd_sweep", {{(DATA_W-1){1'b0}}, ready}, {{(DATA_W-1){1'b0}}, 1'b1});
      cyc(1'b1, 1'b0, ADDR_W'(3), '0);
      check("rd_addr3_cleared", q, '0);

      // Reset mid-operation, then a short random run after the restart.
      cyc(1'b0, 1'b1, ADDR_W'(20), rnd_word());
      sweep_with_noise(DEPTH);
      for (int i = 0; i < 500; i++) begin
         cyc(1'b1, 1'($urandom), ADDR_W'($urandom_range(0, 63)), rnd_word());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_storage.md
RAM_STORAGE -- requirements
Module: ram_storage

Interface
REQ-001 Parameter ADDR_W, default 12, address width in bits.
REQ-002 Parameter DATA_W, default 145, word width in bits.
REQ-003 Parameter DEPTH, default 4096 (2**ADDR_W), number of words.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  ADDR_W  word address for both read and write.
REQ-007 data  input  DATA_W  write data.
REQ-008 wren  input  1  write enable, active-high.
REQ-009 q  output  DATA_W  registered read data.
REQ-010 ready  output  1  high when the post-reset clear sweep is complete and user accesses are accepted.

Function
REQ-011 Storage SHALL be a single-port array of DEPTH words of DATA_W bits.
REQ-012 Read latency SHALL be exactly 1 cycle: q after edge N SHALL equal mem[address sampled at edge N].
REQ-013 While ready=1 and wren=1, mem[address] SHALL take the value of data at the rising edge.
REQ-014 A read SHALL occur every cycle regardless of wren; q SHALL hold its value only during reset or the clear sweep.
REQ-015 Read-during-write to the same address SHALL follow REQ-024/REQ-025.
REQ-016 Address values >= DEPTH (when DEPTH < 2**ADDR_W) SHALL ignore writes and return all-zero q.
REQ-017 Clear sweep: after rst_n is released, the block SHALL write all-zero data to addresses 0..DEPTH-1, one per cycle, in ascending order.
REQ-018 ready SHALL stay 0 during the sweep and SHALL rise on the cycle after address DEPTH-1 is cleared, i.e. DEPTH cycles after rst_n rises.
REQ-019 During the sweep, wren, address and data SHALL be ignored and q SHALL hold all-zero.
REQ-020 Bit 0 of each word is the valid bit used by clients; after the sweep every word, including bit 0, SHALL read as 0.

Reset
REQ-021 While rst_n=0 at a rising edge: q<=0, ready<=0, sweep pointer<=0; user writes SHALL be blocked.
REQ-022 Reset asserted mid-sweep or mid-operation SHALL abort and restart the sweep from address 0 once rst_n returns to 1.
REQ-023 Reset SHALL NOT be needed to make contents defined; the sweep SHALL be the only clear mechanism.

Configuration
REQ-024 With macro RAM_STORAGE_WRITE_THROUGH_EN defined, a same-address write and read at the same edge SHALL return the new data on q.
REQ-025 Without RAM_STORAGE_WRITE_THROUGH_EN, q SHALL return the old stored data for a same-address write and read.

Verification
REQ-026 rst_n=0 for 2 cycles, then 1 -> q=0 throughout; ready rises exactly 4096 cycles later; reading address 0 and 4095 after that gives 0.
REQ-027 After ready: write address 5 with data 145'h1_0000_0000_0000_0000_0000_0000_0000_0000_0001, then read 5 -> q equals that value 1 cycle after the read address is applied.
REQ-028 Write address 7 value A, then same-edge write of B to 7 with address 7 -> q=A without the macro and q=B with RAM_STORAGE_WRITE_THROUGH_EN.
REQ-029 During the sweep, assert wren to address 10 with nonzero data -> after ready, address 10 reads 0.
REQ-030 Write address 3 value X, pulse rst_n low 1 cycle at sweep cycle 100 -> ready delayed to 4096 cycles after the second release; address 3 reads 0.
REQ-031 Back-to-back writes to addresses 0..15 with data equal to the address, then reads 0..15 -> q matches with 1-cycle latency and no gaps.
